// File: rtl/mo_pkg.sv
// Shared opcode, mode and state definitions for the mo_param matrix engine.
package mo_pkg;

  localparam int unsigned OPC_W  = 3;
  localparam int unsigned MODE_W = 2;

  // Memory request opcodes
  localparam logic [OPC_W-1:0] OP_GET_N   = 3'b000;
  localparam logic [OPC_W-1:0] OP_GET_R   = 3'b001;
  localparam logic [OPC_W-1:0] OP_READ_A  = 3'b010;
  localparam logic [OPC_W-1:0] OP_READ_X  = 3'b011;
  localparam logic [OPC_W-1:0] OP_READ_B  = 3'b100;
  localparam logic [OPC_W-1:0] OP_WRITE_Y = 3'b101;
  localparam logic [OPC_W-1:0] OP_GET_M   = 3'b110;
  localparam logic [OPC_W-1:0] OP_NOP     = 3'b111;

  // Job modes; 2'b11 behaves like MODE_PASS
  localparam logic [MODE_W-1:0] MODE_ADD  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SUB  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_PASS = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_GET_N   = 4'd1,
    S_GET_R   = 4'd2,
    S_GET_M   = 4'd3,
    S_CHECK   = 4'd4,
    S_READ_A  = 4'd5,
    S_READ_X  = 4'd6,
    S_TAIL    = 4'd7,
    S_WRITE_Y = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  // True when the mode combines a B operand into the result
  function automatic logic uses_b(input logic [MODE_W-1:0] m);
    return (m == MODE_ADD) || (m == MODE_SUB);
  endfunction

endpackage

// File: rtl/mo_mac.sv
// Multiply-accumulate datapath: A latch, multiplier, wrapping accumulator, +/-B stage.
module mo_mac
  import mo_pkg::*;
#(
  parameter int unsigned DW    = 10,
  parameter int unsigned ACC_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_ld,
  input  logic              acc_en,
  input  logic              acc_clr,
  input  logic [1:0]        mode,
  input  logic [DW-1:0]     in_data,
  output logic [ACC_W-1:0]  y
);

  localparam int unsigned PROD_W = 2 * DW;

  logic [DW-1:0]     a_q;
  logic [ACC_W-1:0]  acc_q;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;
  logic [ACC_W-1:0]  in_ext;

  // Full-width product of the latched A and the current X, fitted to the accumulator
  always_comb begin
    prod     = PROD_W'(a_q) * PROD_W'(in_data);
    prod_ext = ACC_W'(prod);
    in_ext   = ACC_W'(in_data);
  end

  // A latch and accumulator; clear has priority over accumulate
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      acc_q <= '0;
    end else begin
      if (a_ld) begin
        a_q <= in_data;
      end
      if (acc_clr) begin
        acc_q <= '0;
      end else if (acc_en) begin
        acc_q <= acc_q + prod_ext;
      end
    end
  end

  // Final stage: add or subtract B straight off the read bus, or pass the sum
  always_comb begin
    y = acc_q;
    case (mode)
      MODE_ADD: y = acc_q + in_ext;
      MODE_SUB: y = acc_q - in_ext;
      default:  y = acc_q;
    endcase
  end

endmodule

// File: rtl/mo_param.sv
// Matrix engine Y = A*X (+/- B): sequences operand reads and streams Y row-major.
module mo_param
  import mo_pkg::*;
#(
  parameter int unsigned DW    = 10,
  parameter int unsigned IW    = 10,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    in_data,
  output logic [2:0]       opcode,
  output logic [IW-1:0]    i,
  output logic [IW-1:0]    j,
  output logic [ACC_W-1:0] out_data,
  output logic             busy,
  output logic             fin
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [IW-1:0]    n_q, n_d;
  logic [IW-1:0]    r_q, r_d;
  logic [IW-1:0]    m_q, m_d;
  logic [IW-1:0]    row_q, row_d;
  logic [IW-1:0]    col_q, col_d;
  logic [IW-1:0]    k_q, k_d;
  logic             rx_q;
  logic [IW-1:0]    dim_in;

  logic [2:0]       opcode_d;
  logic [IW-1:0]    i_d, j_d;
  logic             busy_d, fin_d;

  logic             a_ld;
  logic             acc_clr;
  logic [ACC_W-1:0] mac_y;

  assign dim_in = IW'(in_data);

  // State, job registers and registered request outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      n_q     <= '0;
      r_q     <= '0;
      m_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      rx_q    <= 1'b0;
      opcode  <= OP_NOP;
      i       <= '0;
      j       <= '0;
      busy    <= 1'b0;
      fin     <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      r_q     <= r_d;
      m_q     <= m_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      rx_q    <= (state_q == S_READ_X);
      opcode  <= opcode_d;
      i       <= i_d;
      j       <= j_d;
      busy    <= busy_d;
      fin     <= fin_d;
    end
  end

  // Next state and index counters
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    r_d     = r_q;
    m_d     = m_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_GET_N;
          mode_d  = mode;
        end
      end
      S_GET_N: state_d = S_GET_R;
      S_GET_R: begin
        n_d     = dim_in;
        state_d = S_GET_M;
      end
      S_GET_M: begin
        r_d     = dim_in;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // M arrives on the bus this cycle, so test it directly
        m_d   = dim_in;
        row_d = '0;
        col_d = '0;
        k_d   = '0;
        if ((n_q == '0) || (dim_in == '0)) begin
          state_d = S_DONE;
        end else if (r_q == '0) begin
          state_d = S_TAIL;
        end else begin
          state_d = S_READ_A;
        end
      end
      S_READ_A: state_d = S_READ_X;
      S_READ_X: begin
        if (k_q != r_q - IW'(1)) begin
          k_d     = k_q + IW'(1);
          state_d = S_READ_A;
        end else begin
          state_d = S_TAIL;
        end
      end
      S_TAIL: state_d = S_WRITE_Y;
      S_WRITE_Y: begin
        k_d = '0;
        if (col_q == m_q - IW'(1)) begin
          col_d = '0;
          row_d = row_q + IW'(1);
          if (row_q == n_q - IW'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = (r_q == '0) ? S_TAIL : S_READ_A;
          end
        end else begin
          col_d   = col_q + IW'(1);
          state_d = (r_q == '0) ? S_TAIL : S_READ_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request decode for the upcoming state, registered so it lines up with that state
  always_comb begin
    opcode_d = OP_NOP;
    i_d      = '0;
    j_d      = '0;
    busy_d   = (state_d != S_IDLE);
    fin_d    = (state_d == S_DONE);
    case (state_d)
      S_GET_N: opcode_d = OP_GET_N;
      S_GET_R: opcode_d = OP_GET_R;
      S_GET_M: opcode_d = OP_GET_M;
      S_READ_A: begin
        opcode_d = OP_READ_A;
        i_d      = row_d;
        j_d      = k_d;
      end
      S_READ_X: begin
        opcode_d = OP_READ_X;
        i_d      = k_d;
        j_d      = col_d;
      end
      S_TAIL: begin
        opcode_d = uses_b(mode_q) ? OP_READ_B : OP_NOP;
        i_d      = row_d;
        j_d      = col_d;
      end
      S_WRITE_Y: begin
        opcode_d = OP_WRITE_Y;
        i_d      = row_d;
        j_d      = col_d;
      end
      default: ;
    endcase
  end

  // Datapath controls: latch A while X is requested, clear between elements
  always_comb begin
    a_ld    = (state_q == S_READ_X);
    acc_clr = (state_q == S_WRITE_Y) || (state_q == S_CHECK);
  end

  mo_mac #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .a_ld    (a_ld),
    .acc_en  (rx_q),
    .acc_clr (acc_clr),
    .mode    (mode_q),
    .in_data (in_data),
    .y       (mac_y)
  );

  // Y is only presented while the WRITE_Y request is on the port
  assign out_data = (state_q == S_WRITE_Y) ? mac_y : '0;

endmodule

// File: tb/tb_mo_param.sv
// Directed self-checking bench for mo_param with a one-cycle-latency operand memory.
module tb_mo_param;

  localparam logic [2:0] OP_GET_N   = 3'b000;
  localparam logic [2:0] OP_READ_A  = 3'b010;
  localparam logic [2:0] OP_READ_X  = 3'b011;
  localparam logic [2:0] OP_READ_B  = 3'b100;
  localparam logic [2:0] OP_WRITE_Y = 3'b101;
  localparam logic [2:0] OP_GET_R   = 3'b001;
  localparam logic [2:0] OP_GET_M   = 3'b110;
  localparam logic [2:0] OP_NOP     = 3'b111;
  localparam int TLEN = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [9:0]  in_data = '0;
  logic [2:0]  opcode;
  logic [9:0]  i, j;
  logic [19:0] out_data;
  logic        busy, fin;

  int checks = 0;
  int errors = 0;

  logic [9:0] a_mem [0:3][0:3];
  logic [9:0] x_mem [0:3][0:3];
  logic [9:0] b_mem [0:3][0:3];
  logic [9:0] tn, tr, tm;

  logic [2:0] req_op = 3'b111;
  logic [9:0] req_i = '0, req_j = '0;

  logic [2:0]  t_op   [0:TLEN-1];
  logic [9:0]  t_i    [0:TLEN-1];
  logic [9:0]  t_j    [0:TLEN-1];
  logic [19:0] t_out  [0:TLEN-1];
  logic        t_fin  [0:TLEN-1];
  logic        t_busy [0:TLEN-1];
  int          t_len = 0;

  mo_param dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .in_data  (in_data),
    .opcode   (opcode),
    .i        (i),
    .j        (j),
    .out_data (out_data),
    .busy     (busy),
    .fin      (fin)
  );

  always #5 clk = ~clk;

  // Capture the request mid-cycle, answer it on the following cycle
  always @(negedge clk) begin
    req_op <= opcode;
    req_i  <= i;
    req_j  <= j;
  end

  always @(posedge clk) begin
    case (req_op)
      OP_GET_N:  in_data <= tn;
      OP_GET_R:  in_data <= tr;
      OP_GET_M:  in_data <= tm;
      OP_READ_A: in_data <= a_mem[req_i[1:0]][req_j[1:0]];
      OP_READ_X: in_data <= x_mem[req_i[1:0]][req_j[1:0]];
      OP_READ_B: in_data <= b_mem[req_i[1:0]][req_j[1:0]];
      default:   in_data <= 10'h155;
    endcase
  end

  task automatic clear_mem();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a_mem[r][c] = '0;
        x_mem[r][c] = '0;
        b_mem[r][c] = '0;
      end
    end
  endtask

  task automatic load_2x2();
    clear_mem();
    a_mem[0][0] = 10'd1; a_mem[0][1] = 10'd2;
    a_mem[1][0] = 10'd3; a_mem[1][1] = 10'd4;
    x_mem[0][0] = 10'd5; x_mem[1][0] = 10'd6;
    b_mem[0][0] = 10'd7; b_mem[1][0] = 10'd8;
    tn = 10'd2; tr = 10'd2; tm = 10'd1;
  endtask

  // Cycle 0 is the first cycle with start high; start is held through cycle hold
  task automatic run_job(input int ncyc, input int hold, input int pulse, input int rst_c);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      t_op[c]   = opcode;
      t_i[c]    = i;
      t_j[c]    = j;
      t_out[c]  = out_data;
      t_fin[c]  = fin;
      t_busy[c] = busy;
      start = (c <= hold) || (c == pulse);
      reset = (c == rst_c);
    end
    t_len = ncyc;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic int nth_fin(input int nth);
    int seen = 0;
    for (int c = 0; c < t_len; c++) begin
      if (t_fin[c] === 1'b1) begin
        if (seen == nth) return c;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int count_op(input logic [2:0] op);
    int n = 0;
    for (int c = 0; c < t_len; c++) if (t_op[c] === op) n++;
    return n;
  endfunction

  function automatic int stray_out();
    int n = 0;
    for (int c = 0; c < t_len; c++) if (t_op[c] !== OP_WRITE_Y && t_out[c] !== 20'd0) n++;
    return n;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (opcode !== OP_NOP) begin errors++; $display("FAIL reset_opcode got %0d want 7", opcode); end
    checks++; if (i !== 10'd0 || j !== 10'd0) begin errors++; $display("FAIL reset_ij got %0d,%0d want 0,0", i, j); end
    checks++; if (out_data !== 20'd0) begin errors++; $display("FAIL reset_out got %0d want 0", out_data); end
    checks++; if (busy !== 1'b0 || fin !== 1'b0) begin errors++; $display("FAIL reset_busy_fin got %b%b want 00", busy, fin); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || opcode !== OP_NOP) begin errors++; $display("FAIL idle_after_reset busy %b op %0d want 0 7", busy, opcode); end
  endtask

  task automatic test_mode_add();
    load_2x2();
    mode = 2'b00;
    run_job(24, 0, -1, -1);
    checks++; if (t_op[1] !== OP_GET_N) begin errors++; $display("FAIL add_getn_c1 got %0d want 0", t_op[1]); end
    checks++; if (t_busy[1] !== 1'b1) begin errors++; $display("FAIL add_busy_c1 got %b want 1", t_busy[1]); end
    checks++; if (t_op[5] !== OP_READ_A || t_i[5] !== 10'd0 || t_j[5] !== 10'd0) begin errors++; $display("FAIL add_reada_c5 got op %0d (%0d,%0d) want 2 (0,0)", t_op[5], t_i[5], t_j[5]); end
    checks++; if (t_op[10] !== OP_WRITE_Y || t_out[10] !== 20'd24) begin errors++; $display("FAIL add_y00 got op %0d val %0d want 5 24", t_op[10], t_out[10]); end
    checks++; if (t_op[16] !== OP_WRITE_Y || t_i[16] !== 10'd1 || t_j[16] !== 10'd0 || t_out[16] !== 20'd47) begin errors++; $display("FAIL add_y10 got op %0d (%0d,%0d) val %0d want 5 (1,0) 47", t_op[16], t_i[16], t_j[16], t_out[16]); end
    checks++; if (nth_fin(0) !== 17) begin errors++; $display("FAIL add_fin_cycle got %0d want 17", nth_fin(0)); end
    checks++; if (t_busy[17] !== 1'b1 || t_busy[18] !== 1'b0) begin errors++; $display("FAIL add_busy_fall got %b%b want 10", t_busy[17], t_busy[18]); end
    checks++; if (stray_out() !== 0) begin errors++; $display("FAIL add_out_outside_write got %0d want 0", stray_out()); end
  endtask

  task automatic test_mode_sub();
    load_2x2();
    mode = 2'b01;
    run_job(20, 0, -1, -1);
    checks++; if (t_out[10] !== 20'd10) begin errors++; $display("FAIL sub_y00 got %0d want 10", t_out[10]); end
    checks++; if (t_out[16] !== 20'd31) begin errors++; $display("FAIL sub_y10 got %0d want 31", t_out[16]); end
    clear_mem();
    b_mem[0][0] = 10'd1;
    tn = 10'd1; tr = 10'd0; tm = 10'd1;
    run_job(12, 0, -1, -1);
    checks++; if (t_op[5] !== OP_READ_B) begin errors++; $display("FAIL sub_r0_tail got %0d want 4", t_op[5]); end
    checks++; if (t_op[6] !== OP_WRITE_Y || t_out[6] !== 20'd1048575) begin errors++; $display("FAIL sub_r0_wrap got op %0d val %0d want 5 1048575", t_op[6], t_out[6]); end
    checks++; if (nth_fin(0) !== 7) begin errors++; $display("FAIL sub_r0_fin got %0d want 7", nth_fin(0)); end
  endtask

  task automatic test_mode_pass();
    clear_mem();
    a_mem[0][0] = 10'd1023; a_mem[0][1] = 10'd1023;
    x_mem[0][0] = 10'd1023; x_mem[1][0] = 10'd1023;
    b_mem[0][0] = 10'd99;
    tn = 10'd1; tr = 10'd2; tm = 10'd1;
    for (int md = 2; md < 4; md++) begin
      mode = 2'(md);
      run_job(16, 0, -1, -1);
      checks++; if (t_op[9] !== OP_NOP) begin errors++; $display("FAIL pass%0d_tail_op got %0d want 7", md, t_op[9]); end
      checks++; if (t_op[10] !== OP_WRITE_Y || t_out[10] !== 20'd1044482) begin errors++; $display("FAIL pass%0d_y got op %0d val %0d want 5 1044482", md, t_op[10], t_out[10]); end
      checks++; if (count_op(OP_READ_B) !== 0) begin errors++; $display("FAIL pass%0d_readb got %0d want 0", md, count_op(OP_READ_B)); end
      checks++; if (nth_fin(0) !== 11) begin errors++; $display("FAIL pass%0d_fin got %0d want 11", md, nth_fin(0)); end
    end
  endtask

  task automatic test_non_square();
    logic [2:0] eo [0:7];
    logic [9:0] ei [0:7];
    logic [9:0] ej [0:7];
    clear_mem();
    a_mem[0][0] = 10'd1; a_mem[0][1] = 10'd2; a_mem[0][2] = 10'd3;
    x_mem[0][0] = 10'd1; x_mem[0][1] = 10'd2;
    x_mem[1][0] = 10'd3; x_mem[1][1] = 10'd4;
    x_mem[2][0] = 10'd5; x_mem[2][1] = 10'd6;
    b_mem[0][0] = 10'd10; b_mem[0][1] = 10'd20;
    tn = 10'd1; tr = 10'd3; tm = 10'd2;
    mode = 2'b00;
    eo = '{OP_READ_A, OP_READ_X, OP_READ_A, OP_READ_X, OP_READ_A, OP_READ_X, OP_READ_B, OP_WRITE_Y};
    ei = '{10'd0, 10'd0, 10'd0, 10'd1, 10'd0, 10'd2, 10'd0, 10'd0};
    ej = '{10'd0, 10'd1, 10'd1, 10'd1, 10'd2, 10'd1, 10'd1, 10'd1};
    run_job(26, 0, -1, -1);
    for (int s = 0; s < 8; s++) begin
      checks++;
      if (t_op[13+s] !== eo[s] || t_i[13+s] !== ei[s] || t_j[13+s] !== ej[s]) begin
        errors++;
        $display("FAIL ns_seq%0d got op %0d (%0d,%0d) want op %0d (%0d,%0d)", s, t_op[13+s], t_i[13+s], t_j[13+s], eo[s], ei[s], ej[s]);
      end
    end
    checks++; if (t_out[12] !== 20'd32) begin errors++; $display("FAIL ns_y00 got %0d want 32", t_out[12]); end
    checks++; if (t_out[20] !== 20'd48) begin errors++; $display("FAIL ns_y01 got %0d want 48", t_out[20]); end
    checks++; if (nth_fin(0) !== 21) begin errors++; $display("FAIL ns_fin got %0d want 21", nth_fin(0)); end
  endtask

  task automatic test_zero_dim();
    int bad;
    clear_mem();
    mode = 2'b00;
    tn = 10'd0; tr = 10'd2; tm = 10'd1;
    run_job(12, 0, -1, -1);
    bad = count_op(OP_READ_A) + count_op(OP_READ_X) + count_op(OP_READ_B) + count_op(OP_WRITE_Y);
    checks++; if (bad !== 0) begin errors++; $display("FAIL n0_reads got %0d want 0", bad); end
    checks++; if (t_op[4] !== OP_NOP) begin errors++; $display("FAIL n0_check_op got %0d want 7", t_op[4]); end
    checks++; if (nth_fin(0) !== 5) begin errors++; $display("FAIL n0_fin got %0d want 5", nth_fin(0)); end
    checks++; if (t_busy[6] !== 1'b0) begin errors++; $display("FAIL n0_busy_c6 got %b want 0", t_busy[6]); end
    tn = 10'd1; tr = 10'd1; tm = 10'd0;
    run_job(10, 0, -1, -1);
    checks++; if (nth_fin(0) !== 5 || count_op(OP_READ_A) !== 0) begin errors++; $display("FAIL m0_fin got %0d reads %0d want 5 0", nth_fin(0), count_op(OP_READ_A)); end
  endtask

  task automatic test_start_while_busy();
    int idle_bad;
    load_2x2();
    mode = 2'b00;
    run_job(26, 0, 8, -1);
    idle_bad = 0;
    for (int c = 18; c < 26; c++) if (t_busy[c] !== 1'b0) idle_bad++;
    checks++; if (nth_fin(0) !== 17) begin errors++; $display("FAIL swb_fin got %0d want 17", nth_fin(0)); end
    checks++; if (count_op(OP_WRITE_Y) !== 2 || t_out[16] !== 20'd47) begin errors++; $display("FAIL swb_writes got %0d last %0d want 2 47", count_op(OP_WRITE_Y), t_out[16]); end
    checks++; if (idle_bad !== 0) begin errors++; $display("FAIL swb_restart got %0d busy cycles want 0", idle_bad); end
  endtask

  task automatic test_back_to_back();
    clear_mem();
    mode = 2'b00;
    tn = 10'd0; tr = 10'd0; tm = 10'd0;
    run_job(16, 6, -1, -1);
    checks++; if (t_busy[6] !== 1'b0 || t_op[7] !== OP_GET_N) begin errors++; $display("FAIL b2b_restart got busy6 %b op7 %0d want 0 0", t_busy[6], t_op[7]); end
    checks++; if (nth_fin(0) !== 5 || nth_fin(1) !== 11) begin errors++; $display("FAIL b2b_fins got %0d,%0d want 5,11", nth_fin(0), nth_fin(1)); end
  endtask

  task automatic test_reset_mid();
    load_2x2();
    mode = 2'b00;
    run_job(14, 0, -1, 12);
    checks++; if (t_op[11] !== OP_READ_A || t_i[11] !== 10'd1 || t_op[12] !== OP_READ_X) begin errors++; $display("FAIL rst_position got op11 %0d i %0d op12 %0d want 2 1 3", t_op[11], t_i[11], t_op[12]); end
    checks++; if (t_op[13] !== OP_NOP || t_i[13] !== 10'd0 || t_j[13] !== 10'd0) begin errors++; $display("FAIL rst_req got op %0d (%0d,%0d) want 7 (0,0)", t_op[13], t_i[13], t_j[13]); end
    checks++; if (t_busy[13] !== 1'b0 || t_fin[13] !== 1'b0 || t_out[13] !== 20'd0) begin errors++; $display("FAIL rst_status got busy %b fin %b out %0d want 0 0 0", t_busy[13], t_fin[13], t_out[13]); end
    run_job(20, 0, -1, -1);
    checks++; if (t_op[1] !== OP_GET_N) begin errors++; $display("FAIL rst_rerun_getn got %0d want 0", t_op[1]); end
    checks++; if (t_out[10] !== 20'd24 || t_out[16] !== 20'd47) begin errors++; $display("FAIL rst_rerun_y got %0d,%0d want 24,47", t_out[10], t_out[16]); end
    checks++; if (nth_fin(0) !== 17) begin errors++; $display("FAIL rst_rerun_fin got %0d want 17", nth_fin(0)); end
  endtask

  initial begin
    clear_mem();
    tn = '0; tr = '0; tm = '0;
    test_reset();
    test_mode_add();
    test_mode_sub();
    test_mode_pass();
    test_non_square();
    test_zero_dim();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mo_param.md
# mo_param

Parametrised matrix engine computing Y = A·X ± B (or A·X) for non-square operands: A is N×R, X is R×M, B and Y are N×M. It drives an external operand memory through an opcode/index request port with one-cycle read latency and emits Y element by element in row-major order. It adds configurable widths, a third dimension M, selectable mode, and a start/busy/fin handshake with an idle state.

## Interface
- DW, 10: operand and dimension data width (in_data)
- IW, 10: index width (i, j, dimension registers)
- ACC_W, 20: accumulator and out_data width; all arithmetic is modulo 2^ACC_W
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- mode  in  2  00 A·X+B, 01 A·X−B, 10 A·X (no B reads), 11 treated as 10; latched on start
- in_data  in  DW  read data, valid one cycle after the request
- opcode  out  3  current request: GET_N 000, GET_R 001, READ_A 010, READ_X 011, READ_B 100, WRITE_Y 101, GET_M 110, NOP 111
- i, j  out  IW  row/column index of the current request
- out_data  out  ACC_W  Y element, valid only while opcode=WRITE_Y, else 0
- busy  out  1  high in every state except IDLE
- fin  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, GET_N, GET_R, GET_M, CHECK, READ_A, READ_X, TAIL, WRITE_Y, DONE. opcode is a registered function of the state: TAIL drives READ_B in modes 00/01 and NOP in mode 10; IDLE, CHECK, and DONE drive NOP.
- IDLE→GET_N on start. Then GET_N→GET_R→GET_M→CHECK. N is captured in GET_R, R in GET_M, and M in CHECK.
- CHECK: if N=0 or M=0, go to DONE. Else if R=0, go to TAIL. Else go to READ_A with row=col=k=0 and acc=0.
- READ_A drives i=row, j=k. READ_X drives i=k, j=col.
- READ_X→READ_A with k+1 while k<R−1, else →TAIL.
- TAIL drives i=row, j=col. TAIL→WRITE_Y.
- Datapath: the A value is latched in the cycle after READ_A. In the cycle after READ_X, acc += a·x (product zero-extended to ACC_W, result wraps).
- WRITE_Y drives i=row, j=col.
  - out_data = acc+in_data (mode 00), acc−in_data (mode 01, two's-complement wrap), or acc (mode 10).
  - in_data is zero-extended.
  - acc clears at the end of WRITE_Y.
- WRITE_Y advances col. When col=M−1, col goes to 0 and row increments. When row=N−1 and col=M−1, go to DONE; else go to READ_A (or TAIL if R=0).
- DONE: fin=1, then IDLE.
- start outside IDLE is ignored. Dimension values wider than IW are truncated to the low IW bits.
- Reset at any cycle, including mid-job: the next state is IDLE and all registers clear.

## Timing
- Reset values: opcode=111, i=j=0, out_data=0, busy=0, fin=0, acc=0, all dimensions 0.
- With start high in cycle 0, GET_N is in cycle 1 and the first READ_A is in cycle 5.
- Each element takes 2R+2 cycles.
- fin is in cycle 5+N·M·(2R+2). With N=0 or M=0, fin is in cycle 5.
- busy falls in the cycle after fin. A new start is accepted in that cycle.
- in_data is sampled strictly one cycle after the request. out_data has a combinational path from in_data in WRITE_Y only.

## Structure
- Shared package mo_pkg holds the opcode constants, mode encodings, and state enum.
- One natural sub-module, mo_mac, covers the A latch, multiplier, ACC_W accumulator, and the final ±B/pass stage. The FSM and index counters live in mo_param.

## Test plan
- Mode 00: N=2, R=2, M=1, A=[[1,2],[3,4]], X=[5,6], B=[7,8] → WRITE_Y out_data 24 (cycle 10) then 47 (cycle 16); fin in cycle 17.
- Mode 01 with the same operands → 10, 31. With R=0 and B=1 → 1048575 (wrap at ACC_W=20).
- Mode 10: N=1, R=2, M=1, A and X all 1023 → 1044482. No READ_B opcode is ever issued; TAIL shows 111.
- Non-square: N=1, R=3, M=2 → index sequence for element (0,1) is A(0,0), X(0,1), A(0,1), X(1,1), A(0,2), X(2,1), B(0,1), then WRITE_Y(0,1). fin in cycle 21.
- N=0 → no reads after CHECK; fin in cycle 5. start pulsed while busy → ignored with no restart.
- reset asserted during READ_X of the second element → the next cycle is IDLE with all outputs at reset values. A fresh start then runs the job correctly from GET_N.
